// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// uart_transmitter_if : byte valid/ready handshake into the UART transmitter
// Revision: 1.0
// ============================================================================
interface uart_transmitter_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// uart_transmitter : 8-bit LSB-first UART TX, optional parity, 1/2 stop bits,
//                    one-byte holding register for gap-free back-to-back frames
// Revision: 1.0
// ============================================================================
module uart_transmitter #(
  parameter int CPB        = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  uart_transmitter_if.slave  i_in,
  output logic               o_tx,
  output logic               o_busy
);

  localparam int            c_cw        = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [c_cw-1:0] c_last    = c_cw'(CPB - 1);
  localparam logic [c_cw-1:0] c_one     = c_cw'(1);
  localparam logic          c_stop_last = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_cw-1:0] r_count;
  logic [2:0]      r_bit_idx;
  logic            r_stop_idx;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [7:0]      r_hold_data;
  logic            r_hold_full;
  logic            r_tx;

  logic w_bit_end;
  logic w_accept;
  logic w_hold_par;

  assign w_bit_end  = (r_count == c_last);
  assign w_accept   = i_in.valid & ~r_hold_full;
  assign w_hold_par = (PARITY_ODD != 0) ? ~^r_hold_data : ^r_hold_data;

  assign i_in.ready = ~r_hold_full;
  assign o_tx       = r_tx;
  assign o_busy     = (r_state != S_IDLE) | r_hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx    <= 1'b1;
          r_count <= '0;
          if (r_hold_full) begin
            r_shift     <= r_hold_data;
            r_parity    <= w_hold_par;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_count   <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_count <= r_count + c_one;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_count <= '0;
            if (r_bit_idx == 3'd7) begin
              r_stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_count <= r_count + c_one;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_count    <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_count <= r_count + c_one;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_count <= '0;
            if (r_stop_idx == c_stop_last) begin
              // A pending byte starts its frame on this very edge: no idle gap
              if (r_hold_full) begin
                r_shift     <= r_hold_data;
                r_parity    <= w_hold_par;
                r_hold_full <= 1'b0;
                r_tx        <= 1'b0;
                r_state     <= S_START;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_count <= r_count + c_one;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_count <= '0;
          r_state <= S_IDLE;
        end
      endcase

      // Accept and transfer never coincide: transfer needs the register full, accept needs it empty
      if (w_accept) begin
        r_hold_data <= i_in.data;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// tb_uart_transmitter : directed checks of the UART transmitter, plus loopback
// Revision: 1.0
// ============================================================================
module tb_uart_transmitter;

  localparam int C_CPB  = 434;
  localparam int C_CPB2 = 16;
  localparam int C_CPB3 = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx0, tx1, tx2, tx3;
  logic busy0, busy1, busy2, busy3;

  int n_total = 0;
  int n_bad   = 0;
  int busy_acc;
  int ready_acc;
  int rx_err  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  uart_transmitter_if if0 ();
  uart_transmitter_if if1 ();
  uart_transmitter_if if2 ();
  uart_transmitter_if if3 ();

  uart_transmitter #(.CPB(C_CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_in(if0), .o_tx(tx0), .o_busy(busy0));
  uart_transmitter #(.CPB(C_CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_in(if1), .o_tx(tx1), .o_busy(busy1));
  uart_transmitter #(.CPB(C_CPB2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_in(if2), .o_tx(tx2), .o_busy(busy2));
  uart_transmitter #(.CPB(C_CPB3), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_in(if3), .o_tx(tx3), .o_busy(busy3));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0: return tx0;
      1: return tx1;
      2: return tx2;
      default: return tx3;
    endcase
  endfunction

  function automatic int get_busy(input int sel);
    case (sel)
      0: return int'(busy0);
      1: return int'(busy1);
      2: return int'(busy2);
      default: return int'(busy3);
    endcase
  endfunction

  function automatic int get_ready(input int sel);
    case (sel)
      0: return int'(if0.ready);
      1: return int'(if1.ready);
      2: return int'(if2.ready);
      default: return int'(if3.ready);
    endcase
  endfunction

  task automatic set_in(input int sel, input logic [7:0] b, input logic v);
    case (sel)
      0: begin if0.data = b; if0.valid = v; end
      1: begin if1.data = b; if1.valid = v; end
      2: begin if2.data = b; if2.valid = v; end
      default: begin if3.data = b; if3.valid = v; end
    endcase
  endtask

  // Offer a byte at the current falling edge; returns one cycle later with valid dropped
  task automatic offer(input int sel, input logic [7:0] b);
    set_in(sel, b, 1'b1);
    @(negedge clk);
    check("accept_ready_low", 32'(get_ready(sel)), 32'd0);
    set_in(sel, 8'h00, 1'b0);
  endtask

  task automatic level(input int sel, input string tag, input logic lvl, input int n);
    int hit;
    hit = 0;
    for (int i = 0; i < n; i++) begin
      if (get_tx(sel) === lvl) hit++;
      busy_acc  += get_busy(sel);
      ready_acc += get_ready(sel);
      @(negedge clk);
    end
    check(tag, 32'(hit), 32'(n));
  endtask

  task automatic frame(input int sel, input logic [7:0] b, input int start_n, input logic pe,
                       input logic pb, input int nstop, input int cpb);
    level(sel, "start_bit", 1'b0, start_n);
    for (int i = 0; i < 8; i++) level(sel, "data_bit", b[i], cpb);
    if (pe) level(sel, "parity_bit", pb, cpb);
    level(sel, "stop_bits", 1'b1, nstop * cpb);
  endtask

  task automatic count_toggles(input int n, output int tog);
    logic prev;
    tog  = 0;
    prev = tx0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx0 !== prev) tog++;
      prev = tx0;
    end
  endtask

  // Reference receiver on the loopback instance, sampling mid-bit
  always begin
    logic [7:0] rb;
    @(negedge tx3);
    repeat (C_CPB3 / 2 + 1) @(negedge clk);
    if (tx3 !== 1'b0) rx_err++;
    for (int k = 0; k < 8; k++) begin
      repeat (C_CPB3) @(negedge clk);
      rb[k] = tx3;
    end
    repeat (C_CPB3) @(negedge clk);
    if (tx3 !== 1'b1) rx_err++;
    rx_q.push_back(rb);
  end

  initial begin
    int tog;
    int t;
    int timeouts;
    logic [7:0] b;

    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) set_in(s, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx0), 32'd1);
    check("reset_ready", 32'(if0.ready), 32'd1);
    check("reset_busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset while idle, then a quiet line
    rst_n = 1'b0;
    #1;
    check("idle_reset_tx", 32'(tx0), 32'd1);
    check("idle_reset_ready", 32'(if0.ready), 32'd1);
    check("idle_reset_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_toggles(5000, tog);
    check("idle_toggles", 32'(tog), 32'd0);

    // Single 0x55 frame with default parameters
    offer(0, 8'h55);
    check("pre_start_tx", 32'(tx0), 32'd1);
    busy_acc = get_busy(0);
    @(negedge clk);
    frame(0, 8'h55, C_CPB, 1'b0, 1'b0, 1, C_CPB);
    check("busy_after_frame", 32'(busy0), 32'd0);
    check("busy_cycles_55", 32'(busy_acc), 32'd4341);
    repeat (10) @(negedge clk);

    // Back to back: 0xA5, then 0x3C accepted during the start bit
    offer(0, 8'hA5);
    @(negedge clk);
    check("b2b_fall", 32'(tx0), 32'd0);
    set_in(0, 8'h3C, 1'b1);
    @(negedge clk);
    check("b2b_accept", 32'(if0.ready), 32'd0);
    set_in(0, 8'h00, 1'b0);
    ready_acc = 0;
    frame(0, 8'hA5, C_CPB - 1, 1'b0, 1'b0, 1, C_CPB);
    check("b2b_ready_held_low", 32'(ready_acc), 32'd0);
    check("b2b_ready_freed", 32'(if0.ready), 32'd1);
    frame(0, 8'h3C, C_CPB, 1'b0, 1'b0, 1, C_CPB);
    check("b2b_busy_end", 32'(busy0), 32'd0);

    // Even parity, two stop bits: 0x07 -> parity 1, frame 12 bits
    offer(1, 8'h07);
    busy_acc = get_busy(1);
    @(negedge clk);
    frame(1, 8'h07, C_CPB, 1'b1, 1'b1, 2, C_CPB);
    check("par_even_busy_cycles", 32'(busy_acc), 32'd5209);
    check("par_even_busy_end", 32'(busy1), 32'd0);

    // Odd parity: 0x07 -> parity 0
    offer(2, 8'h07);
    @(negedge clk);
    frame(2, 8'h07, C_CPB2, 1'b1, 1'b0, 1, C_CPB2);
    check("par_odd_busy_end", 32'(busy2), 32'd0);

    // Reset during data bit 3 of 0xF0 with 0x11 pending
    offer(0, 8'hF0);
    @(negedge clk);
    check("rst_frame_fall", 32'(tx0), 32'd0);
    set_in(0, 8'h11, 1'b1);
    @(negedge clk);
    check("rst_pending_accept", 32'(if0.ready), 32'd0);
    set_in(0, 8'h00, 1'b0);
    level(0, "start_bit", 1'b0, C_CPB - 1);
    for (int i = 0; i < 3; i++) level(0, "data_bit", 1'b0, C_CPB);
    repeat (200) @(negedge clk);
    check("rst_mid_bit3", 32'(tx0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx0), 32'd1);
    check("rst_async_ready", 32'(if0.ready), 32'd1);
    check("rst_async_busy", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_toggles(1000, tog);
    check("rst_pending_dropped", 32'(tog), 32'd0);
    offer(0, 8'h22);
    @(negedge clk);
    frame(0, 8'h22, C_CPB, 1'b0, 1'b0, 1, C_CPB);

    // Loopback: 256 random bytes back to back
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      set_in(3, b, 1'b1);
      t = 0;
      while (!if3.ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      set_in(3, 8'h00, 1'b0);
      if (t >= 100) timeouts++;
      tx_q.push_back(b);
    end
    check("lb_accept_timeouts", 32'(timeouts), 32'd0);
    t = 0;
    while (busy3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("lb_drain", 32'(busy3), 32'd0);
    repeat (10) @(negedge clk);
    check("lb_count", 32'(rx_q.size()), 32'd256);
    check("lb_frame_err", 32'(rx_err), 32'd0);
    for (int i = 0; i < 256 && i < rx_q.size(); i++) check("lb_data", 32'(rx_q[i]), 32'(tx_q[i]));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
